// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format and opcode definitions for the RV64IM+Zicsr encode/decode path.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_CSR = 3'd6
    } enc_fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Places immediate bits into their format-specific slots and flags immediates that cannot be encoded.
module enc_imm_pack
    import instr_encoder_pkg::*;
(
    input  enc_fmt_t    fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] imm,
    output logic [31:0] imm_bits,
    output logic        err
);

    logic fits12, fits13, fits21, fits32, shift_f3;

    // A value fits an N-bit signed field when all bits from N-1 upward are identical.
    assign fits12   = (&imm[63:11]) | ~(|imm[63:11]);
    assign fits13   = (&imm[63:12]) | ~(|imm[63:12]);
    assign fits21   = (&imm[63:20]) | ~(|imm[63:20]);
    assign fits32   = (&imm[63:31]) | ~(|imm[63:31]);
    assign shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        imm_bits = '0;
        err      = 1'b0;
        case (fmt)
            FMT_R, FMT_CSR: begin
                imm_bits = '0;
            end
            FMT_I: begin
                if (opcode == OP_IMM && shift_f3) begin
                    imm_bits = {funct7[6:1], imm[5:0], 20'b0};
                end else if (opcode == OP_IMM32 && shift_f3) begin
                    imm_bits = {funct7, imm[4:0], 20'b0};
                    err      = imm[5];
                end else begin
                    imm_bits = {imm[11:0], 20'b0};
                    err      = !fits12;
                end
            end
            FMT_S: begin
                imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                err      = !fits12;
            end
            FMT_B: begin
                imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                err      = !fits13 || imm[0];
            end
            FMT_U: begin
                imm_bits = {imm[31:12], 12'b0};
                err      = (|imm[11:0]) || !fits32;
            end
            FMT_J: begin
                imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                err      = !fits21 || imm[0];
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into a 32-bit word behind a 2-entry output buffer with delivery counters.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [63:0]      in_imm,
    input  logic [11:0]      in_csr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    enc_fmt_t    fmt;
    logic [31:0] imm_bits;
    logic        imm_err;
    logic [31:0] word;
    logic [31:0] enc_word;

    logic [31:0] rd_f, rs1_f, rs2_f, f3_f, f7_f, csr_f;

    logic [31:0] buf_instr [2];
    logic        buf_err   [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  occ;
    logic        push, pop;

    assign fmt = enc_fmt_t'(in_fmt);

    enc_imm_pack u_imm_pack (
        .fmt      (fmt),
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .imm      (in_imm),
        .imm_bits (imm_bits),
        .err      (imm_err)
    );

    assign rd_f  = {20'b0, in_rd, 7'b0};
    assign f3_f  = {17'b0, in_funct3, 12'b0};
    assign rs1_f = {12'b0, in_rs1, 15'b0};
    assign rs2_f = {7'b0, in_rs2, 20'b0};
    assign f7_f  = {in_funct7, 25'b0};
    assign csr_f = {in_csr, 20'b0};

    always_comb begin
        word = {25'b0, in_opcode} | imm_bits;
        case (fmt)
            FMT_R:        word = word | f7_f | rs2_f | rs1_f | f3_f | rd_f;
            FMT_I:        word = word | rs1_f | f3_f | rd_f;
            FMT_S, FMT_B: word = word | rs2_f | rs1_f | f3_f;
            FMT_U, FMT_J: word = word | rd_f;
            FMT_CSR:      word = word | csr_f | rs1_f | f3_f | rd_f;
            default:      word = '0;
        endcase
    end

    // Unencodable bundles still occupy a slot so downstream ordering is preserved.
    assign enc_word = imm_err ? 32'h0 : word;

    assign in_ready  = resetn && (occ != FULL);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? buf_instr[rd_ptr] : 32'h0;
    assign out_err   = out_valid ? buf_err[rd_ptr] : 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= '0;
                buf_err[i]   <= 1'b0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
            enc_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= enc_word;
                buf_err[wr_ptr]   <= imm_err;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                enc_cnt <= enc_cnt + CNT_W'(1);
                if (buf_err[rd_ptr]) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing vectors, range errors, backpressure, reset and round-trip decode.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [63:0] in_imm;
    logic [11:0] in_csr;
    logic        out_valid, out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [31:0] enc_cnt, err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    instr_encoder #(.DEPTH(2), .CNT_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_csr    (in_csr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_cnt   (enc_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [63:0] imm, input logic [11:0] csr);
        in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_csr = csr;
    endtask

    task automatic send(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                        input logic [11:0] csr, output logic [31:0] instr, output logic err);
        drive(fmt, op, f3, f7, rd, rs1, rs2, imm, csr);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, " in_ready"}, 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " latency"}, 96'(out_valid), 96'(1));
        instr = out_instr;
        err   = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                       input logic [11:0] csr, input logic [31:0] exp_instr, input logic exp_err);
        logic [31:0] instr;
        logic        err;
        send(tag, fmt, op, f3, f7, rd, rs1, rs2, imm, csr, instr, err);
        chk({tag, " instr"}, 96'(instr), 96'(exp_instr));
        chk({tag, " err"}, 96'(err), 96'(exp_err));
    endtask

    // Independent decoder returning {rd, rs1, rs2, funct3, imm}; unused fields read as zero.
    function automatic logic [81:0] decode(input logic [2:0] fmt, input logic [31:0] w);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [63:0] imm;
        rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20]; f3 = w[14:12];
        case (fmt)
            FMT_I: begin imm = {{52{w[31]}}, w[31:20]}; rs2 = '0; end
            FMT_S: begin imm = {{52{w[31]}}, w[31:25], w[11:7]}; rd = '0; end
            FMT_B: begin imm = {{52{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; rd = '0; end
            FMT_U: begin imm = {{32{w[31]}}, w[31:12], 12'b0}; rs1 = '0; rs2 = '0; f3 = '0; end
            FMT_J: begin imm = {{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; rs1 = '0; rs2 = '0; f3 = '0; end
            default: begin imm = '0; end
        endcase
        return {rd, rs1, rs2, f3, imm};
    endfunction

    initial begin
        logic [31:0] r, r2, instr;
        logic        err;
        logic [2:0]  fmt, f3;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [81:0] exp_fields;
        int          sel;

        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(FMT_R, 7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 64'h0, 12'h0);
        #1;
        chk("reset in_ready", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        chk("reset out_valid", 96'(out_valid), 96'(0));
        chk("reset out_instr", 96'(out_instr), 96'(0));
        chk("reset out_err", 96'(out_err), 96'(0));
        chk("reset enc_cnt", 96'(enc_cnt), 96'(0));
        chk("reset err_cnt", 96'(err_cnt), 96'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;

        vec("addi", FMT_I, OP_IMM, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 12'h0, 32'hFFF10093, 1'b0);
        vec("sd", FMT_S, OP_STORE, 3'b011, 7'h0, 5'd0, 5'd2, 5'd5, 64'd8, 12'h0, 32'h00513423, 1'b0);
        vec("beq", FMT_B, OP_BRANCH, 3'b000, 7'h0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 12'h0, 32'hFE000EE3, 1'b0);
        vec("b_odd", FMT_B, OP_BRANCH, 3'b000, 7'h0, 5'd0, 5'd0, 5'd0, 64'd3, 12'h0, 32'h0, 1'b1);
        chk("cnt enc after b_odd", 96'(enc_cnt), 96'(4));
        chk("cnt err after b_odd", 96'(err_cnt), 96'(1));

        vec("lui", FMT_U, OP_LUI, 3'b000, 7'h0, 5'd5, 5'd0, 5'd0, 64'h0000_0000_1234_5000, 12'h0, 32'h123452B7, 1'b0);
        vec("u_nosext", FMT_U, OP_LUI, 3'b000, 7'h0, 5'd5, 5'd0, 5'd0, 64'h0000_0000_8000_0000, 12'h0, 32'h0, 1'b1);
        vec("jal", FMT_J, OP_JAL, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 64'd2048, 12'h0, 32'h001000EF, 1'b0);
        vec("slli63", FMT_I, OP_IMM, 3'b001, 7'b0000000, 5'd3, 5'd4, 5'd0, 64'd63, 12'h0, 32'h03F21193, 1'b0);
        vec("srai_junk", FMT_I, OP_IMM, 3'b101, 7'b0100000, 5'd3, 5'd4, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 12'h0, 32'h43F25193, 1'b0);
        vec("slliw32", FMT_I, OP_IMM32, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd0, 64'd32, 12'h0, 32'h0, 1'b1);
        vec("sraiw5", FMT_I, OP_IMM32, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd0, 64'd5, 12'h0, 32'h4051509B, 1'b0);
        vec("add", FMT_R, OP_REG, 3'b000, 7'h0, 5'd3, 5'd1, 5'd2, 64'h0, 12'h0, 32'h002081B3, 1'b0);
        vec("csrrw", FMT_CSR, OP_SYSTEM, 3'b001, 7'h0, 5'd1, 5'd2, 5'd0, 64'h0, 12'h300, 32'h300110F3, 1'b0);
        vec("fmt7", 3'b111, OP_IMM, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 64'd1, 12'h0, 32'h0, 1'b1);
        vec("i_2048", FMT_I, OP_IMM, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 64'd2048, 12'h0, 32'h0, 1'b1);
        vec("i_m2048", FMT_I, OP_IMM, 3'b000, 7'h0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800, 12'h0, 32'h80000013, 1'b0);
        chk("cnt enc after vectors", 96'(enc_cnt), 96'(16));
        chk("cnt err after vectors", 96'(err_cnt), 96'(5));

        // Backpressure: A and B fill the buffer, C must wait.
        drive(FMT_I, OP_IMM, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 12'h0);
        in_valid = 1'b1;
        chk("bp A in_ready", 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        drive(FMT_S, OP_STORE, 3'b011, 7'h0, 5'd0, 5'd2, 5'd5, 64'd8, 12'h0);
        chk("bp B in_ready", 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        drive(FMT_R, OP_REG, 3'b000, 7'h0, 5'd3, 5'd1, 5'd2, 64'h0, 12'h0);
        chk("bp C in_ready full", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        chk("bp stall in_ready", 96'(in_ready), 96'(0));
        chk("bp stall head A", 96'(out_instr), 96'(32'hFFF10093));
        out_ready = 1'b1;
        #1;
        chk("bp in_ready ignores out_ready", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        chk("bp head B", 96'(out_instr), 96'(32'h00513423));
        chk("bp C in_ready after pop", 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp head C", 96'(out_instr), 96'(32'h002081B3));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp drained", 96'(out_valid), 96'(0));
        chk("cnt enc after bp", 96'(enc_cnt), 96'(19));

        for (int k = 0; k < 20; k++) begin
            r   = $urandom;
            r2  = $urandom;
            sel = $urandom_range(0, 4);
            rd = r2[4:0]; rs1 = r2[9:5]; rs2 = r2[14:10]; f3 = r2[17:15];
            case (sel)
                0: begin fmt = FMT_I; op = OP_LOAD;   imm = {{52{r[11]}}, r[11:0]};
                         exp_fields = {rd, rs1, 5'd0, f3, imm}; end
                1: begin fmt = FMT_S; op = OP_STORE;  imm = {{52{r[11]}}, r[11:0]};
                         exp_fields = {5'd0, rs1, rs2, f3, imm}; end
                2: begin fmt = FMT_B; op = OP_BRANCH; imm = {{51{r[12]}}, r[12:1], 1'b0};
                         exp_fields = {5'd0, rs1, rs2, f3, imm}; end
                3: begin fmt = FMT_U; op = OP_LUI;    imm = {{32{r[31]}}, r[31:12], 12'b0};
                         exp_fields = {rd, 5'd0, 5'd0, 3'd0, imm}; end
                default: begin fmt = FMT_J; op = OP_JAL; imm = {{43{r[20]}}, r[20:1], 1'b0};
                         exp_fields = {rd, 5'd0, 5'd0, 3'd0, imm}; end
            endcase
            send("rt", fmt, op, f3, 7'h0, rd, rs1, rs2, imm, 12'h0, instr, err);
            chk("rt err", 96'(err), 96'(0));
            chk("rt opcode", 96'(instr[6:0]), 96'(op));
            chk("rt fields", 96'(decode(fmt, instr)), 96'(exp_fields));
        end
        chk("cnt enc after rt", 96'(enc_cnt), 96'(39));
        chk("cnt err after rt", 96'(err_cnt), 96'(5));

        // Fill the buffer, then pulse reset between clock edges.
        drive(FMT_I, OP_IMM, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 64'd1, 12'h0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst full out_valid", 96'(out_valid), 96'(1));
        chk("rst full in_ready", 96'(in_ready), 96'(0));
        #2;
        resetn = 1'b0;
        #1;
        chk("rst mid out_valid", 96'(out_valid), 96'(0));
        chk("rst mid out_instr", 96'(out_instr), 96'(0));
        chk("rst mid enc_cnt", 96'(enc_cnt), 96'(0));
        chk("rst mid err_cnt", 96'(err_cnt), 96'(0));
        chk("rst mid in_ready", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        chk("rst held in_ready", 96'(in_ready), 96'(0));
        resetn = 1'b1;
        #1;
        chk("rst release in_ready", 96'(in_ready), 96'(1));
        chk("rst release out_valid", 96'(out_valid), 96'(0));
        vec("post_rst sd", FMT_S, OP_STORE, 3'b011, 7'h0, 5'd0, 5'd2, 5'd5, 64'd8, 12'h0, 32'h00513423, 1'b0);
        chk("cnt enc post_rst", 96'(enc_cnt), 96'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
